// File: rtl/wb_writeback_unit_if.sv
// MEM-stage, SRAM and register-file write-port signals of the write-back unit.
// master drives the MEM/SRAM side. slave is the write-back unit.
interface wb_writeback_unit_if #(
   parameter int unsigned DATA_W = 32
);
   logic              freeze;
   logic              mem_valid;
   logic              mem_wb_en;
   logic              mem_r_en;
   logic [3:0]        mem_dest;
   logic [DATA_W-1:0] mem_alu_res;
   logic [DATA_W-1:0] sram_rdata;
   logic              sram_ready;

   logic [3:0]        dest_wb;
   logic [DATA_W-1:0] Result_WB;
   logic              writeBackEn;
   logic              mem_stall;
   logic              wb_fwd_valid;
   logic [3:0]        wb_fwd_dest;
   logic [31:0]       retire_cnt;
   logic              drop_r15;

   modport master (
      output freeze, mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_res,
             sram_rdata, sram_ready,
      input  dest_wb, Result_WB, writeBackEn, mem_stall, wb_fwd_valid, wb_fwd_dest,
             retire_cnt, drop_r15
   );

   modport slave (
      input  freeze, mem_valid, mem_wb_en, mem_r_en, mem_dest, mem_alu_res,
             sram_rdata, sram_ready,
      output dest_wb, Result_WB, writeBackEn, mem_stall, wb_fwd_valid, wb_fwd_dest,
             retire_cnt, drop_r15
   );
endinterface

// File: rtl/wb_writeback_unit.sv
// Write-back stage: registers the register-file write port, waits out slow SRAM loads
// and drops writes to the unimplemented r15.
module wb_writeback_unit #(
   parameter int unsigned DATA_W = 32
) (
   input logic                clk,
   input logic                rst,
   wb_writeback_unit_if.slave bus
);

   typedef enum logic [0:0] {
      StIdle,
      StLoadWait
   } state_e;

   localparam logic [3:0] RegUnimpl = 4'hF;

   state_e            state_q, state_d;
   logic [3:0]        dest_q, dest_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              wben_q, wben_d;
   logic [3:0]        lat_dest_q, lat_dest_d;
   logic              lat_wb_en_q, lat_wb_en_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              drop_q, drop_d;

   logic              stall;
   logic              commit;
   logic              wr_en;
   logic [3:0]        wr_dest;

   // Combinational so the MEM stage holds the load in the very cycle it is seen.
   always_comb begin
      stall = ((state_q == StLoadWait) & ~bus.sram_ready) |
              ((state_q == StIdle) & bus.mem_valid & bus.mem_r_en & ~bus.sram_ready);
   end

   always_comb begin
      state_d     = state_q;
      dest_d      = dest_q;
      res_d       = res_q;
      wben_d      = 1'b0;
      lat_dest_d  = lat_dest_q;
      lat_wb_en_d = lat_wb_en_q;
      drop_d      = drop_q;
      commit      = 1'b0;
      wr_en       = 1'b0;
      wr_dest     = 4'd0;

      unique case (state_q)
         StIdle: begin
            if (bus.mem_valid && !bus.freeze) begin
               if (bus.mem_r_en && !bus.sram_ready) begin
                  state_d     = StLoadWait;
                  lat_dest_d  = bus.mem_dest;
                  lat_wb_en_d = bus.mem_wb_en;
               end else begin
                  res_d   = bus.mem_r_en ? bus.sram_rdata : bus.mem_alu_res;
                  dest_d  = bus.mem_dest;
                  commit  = 1'b1;
                  wr_en   = bus.mem_wb_en;
                  wr_dest = bus.mem_dest;
               end
            end
         end
         StLoadWait: begin
            // Freeze is ignored here so an outstanding SRAM completion is never lost.
            if (bus.sram_ready) begin
               state_d = StIdle;
               res_d   = bus.sram_rdata;
               dest_d  = lat_dest_q;
               commit  = 1'b1;
               wr_en   = lat_wb_en_q;
               wr_dest = lat_dest_q;
            end
         end
         default: state_d = StIdle;
      endcase

      if (commit) begin
         wben_d = wr_en & (wr_dest != RegUnimpl);
         if (wr_en && (wr_dest == RegUnimpl)) begin
            drop_d = 1'b1;
         end
      end

      cnt_d = wben_d ? cnt_q + 32'd1 : cnt_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         dest_q      <= 4'd0;
         res_q       <= '0;
         wben_q      <= 1'b0;
         lat_dest_q  <= 4'd0;
         lat_wb_en_q <= 1'b0;
         cnt_q       <= 32'd0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dest_q      <= dest_d;
         res_q       <= res_d;
         wben_q      <= wben_d;
         lat_dest_q  <= lat_dest_d;
         lat_wb_en_q <= lat_wb_en_d;
         cnt_q       <= cnt_d;
         drop_q      <= drop_d;
      end
   end

   assign bus.dest_wb      = dest_q;
   assign bus.Result_WB    = res_q;
   assign bus.writeBackEn  = wben_q;
   assign bus.mem_stall    = stall;
   assign bus.wb_fwd_valid = wben_q;
   assign bus.wb_fwd_dest  = dest_q;
   assign bus.retire_cnt   = cnt_q;
   assign bus.drop_r15     = drop_q;

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Scoreboard bench for wb_writeback_unit: stimulus queues expected writes, a negedge
// monitor pops one per writeBackEn pulse.
module tb_wb_writeback_unit;

   typedef struct packed {
      logic [3:0]  dest;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   exp_t exp_q[$];
   int   n_cmp;
   int   n_err;
   int   stall_cnt;

   wb_writeback_unit_if #(.DATA_W(32)) bus ();

   wb_writeback_unit #(.DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic set_in(input logic v, input logic wb, input logic ren, input logic [3:0] d,
                         input logic [31:0] alu, input logic [31:0] rd, input logic rdy,
                         input logic frz);
      bus.mem_valid   = v;
      bus.mem_wb_en   = wb;
      bus.mem_r_en    = ren;
      bus.mem_dest    = d;
      bus.mem_alu_res = alu;
      bus.sram_rdata  = rd;
      bus.sram_ready  = rdy;
      bus.freeze      = frz;
   endtask

   task automatic idle_in();
      set_in(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every write pulse must match the oldest expected write.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         chk("fwd_valid", 32'(bus.wb_fwd_valid), 32'(bus.writeBackEn));
         chk("fwd_dest", 32'(bus.wb_fwd_dest), 32'(bus.dest_wb));
         if (bus.writeBackEn === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_write: got dest %0d data %h, expected no write",
                        bus.dest_wb, bus.Result_WB);
            end else begin
               e = exp_q.pop_front();
               chk("wb_dest", 32'(bus.dest_wb), 32'(e.dest));
               chk("wb_data", bus.Result_WB, e.data);
            end
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      idle_in();
      #8;
      chk("rst_dest", 32'(bus.dest_wb), 32'd0);
      chk("rst_result", bus.Result_WB, 32'd0);
      chk("rst_wben", 32'(bus.writeBackEn), 32'd0);
      chk("rst_retire", bus.retire_cnt, 32'd0);
      chk("rst_drop", 32'(bus.drop_r15), 32'd0);
      #4 rst = 1'b0;

      // ALU stream, back to back.
      step(); set_in(1'b1, 1'b1, 1'b0, 4'd3, 32'h11, 32'h0, 1'b0, 1'b0);
      exp_q.push_back('{dest: 4'd3, data: 32'h11});
      step(); set_in(1'b1, 1'b1, 1'b0, 4'd4, 32'h22, 32'h0, 1'b0, 1'b0);
      exp_q.push_back('{dest: 4'd4, data: 32'h22});
      step(); set_in(1'b1, 1'b1, 1'b0, 4'd5, 32'h33, 32'h0, 1'b0, 1'b0);
      exp_q.push_back('{dest: 4'd5, data: 32'h33});
      step(); idle_in();
      step();
      @(negedge clk);
      chk("retire_after_alu", bus.retire_cnt, 32'd3);

      // Non-writing op, then a load whose data is ready immediately.
      step(); set_in(1'b1, 1'b0, 1'b0, 4'd2, 32'h77, 32'h0, 1'b0, 1'b0);
      step(); set_in(1'b1, 1'b1, 1'b1, 4'd8, 32'h40, 32'hCAFEF00D, 1'b1, 1'b0);
      exp_q.push_back('{dest: 4'd8, data: 32'hCAFEF00D});
      @(negedge clk);
      chk("fast_load_no_stall", 32'(bus.mem_stall), 32'd0);
      step(); idle_in();
      step();
      @(negedge clk);
      chk("retire_after_fast_load", bus.retire_cnt, 32'd4);

      // Slow load: ready low for four cycles.
      exp_q.push_back('{dest: 4'd7, data: 32'hDEADBEEF});
      stall_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i < 4) set_in(1'b1, 1'b1, 1'b1, 4'd7, 32'h80, 32'h0, 1'b0, 1'b0);
         else if (i == 4) set_in(1'b1, 1'b1, 1'b1, 4'd7, 32'h80, 32'hDEADBEEF, 1'b1, 1'b0);
         else idle_in();
         @(negedge clk);
         if (bus.mem_stall === 1'b1) stall_cnt++;
      end
      chk("slow_load_stall_cycles", 32'(stall_cnt), 32'd4);
      step();
      @(negedge clk);
      chk("retire_after_slow_load", bus.retire_cnt, 32'd5);

      // Freeze blocks a valid ALU op for three cycles; outputs hold.
      for (int i = 0; i < 3; i++) begin
         step(); set_in(1'b1, 1'b1, 1'b0, 4'd9, 32'h99, 32'h0, 1'b0, 1'b1);
         @(negedge clk);
         chk("freeze_hold_dest", 32'(bus.dest_wb), 32'd7);
         chk("freeze_hold_result", bus.Result_WB, 32'hDEADBEEF);
      end
      step(); set_in(1'b1, 1'b1, 1'b0, 4'd9, 32'h99, 32'h0, 1'b0, 1'b0);
      exp_q.push_back('{dest: 4'd9, data: 32'h99});
      step(); idle_in();
      @(negedge clk);
      chk("freeze_release_pulse", 32'(bus.writeBackEn), 32'd1);
      step();
      @(negedge clk);
      chk("retire_after_freeze", bus.retire_cnt, 32'd6);

      // Write to r15 is dropped.
      chk("drop_before", 32'(bus.drop_r15), 32'd0);
      step(); set_in(1'b1, 1'b1, 1'b0, 4'd15, 32'hF0F0, 32'h0, 1'b0, 1'b0);
      step(); idle_in();
      step();
      @(negedge clk);
      chk("drop_after", 32'(bus.drop_r15), 32'd1);
      chk("retire_after_r15", bus.retire_cnt, 32'd6);

      // Reset while a load is pending.
      step(); set_in(1'b1, 1'b1, 1'b1, 4'd6, 32'h60, 32'h0, 1'b0, 1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_dest", 32'(bus.dest_wb), 32'd0);
      chk("async_rst_result", bus.Result_WB, 32'd0);
      chk("async_rst_wben", 32'(bus.writeBackEn), 32'd0);
      chk("async_rst_retire", bus.retire_cnt, 32'd0);
      chk("async_rst_drop", 32'(bus.drop_r15), 32'd0);
      idle_in();
      @(negedge clk);
      rst = 1'b0;
      step(); set_in(1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h1234, 1'b1, 1'b0);
      step(); idle_in();
      @(negedge clk);
      chk("post_rst_idle", 32'(bus.mem_stall), 32'd0);
      step();
      step();
      @(negedge clk);
      chk("post_rst_retire", bus.retire_cnt, 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/wb_writeback_unit.md
# wb_writeback_unit

Write-back stage driving the register file's write port (destination index, result data, write enable) from the MEM-stage outputs. Selects between the ALU result and SRAM load data, waits for slow SRAM loads with a small FSM that stalls the MEM stage, and suppresses writes to index 15, which the register file does not implement. Outputs are registered on the rising edge so they stay stable through the falling-edge write in the register file. Also exports the write-back destination for the forwarding unit and keeps a retired-write counter.

## Interface
- `DATA_W`, 32, width of result data.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `freeze` input 1: global pipeline freeze; when high, nothing is accepted.
- `mem_valid` input 1: the MEM stage holds a valid instruction.
- `mem_wb_en` input 1: the instruction writes a register.
- `mem_r_en` input 1: the instruction is a load; data comes from SRAM.
- `mem_dest` input 4: destination register index.
- `mem_alu_res` input DATA_W: ALU result (address for loads, value otherwise).
- `sram_rdata` input DATA_W: SRAM read data; valid when `sram_ready` is high.
- `sram_ready` input 1: SRAM read data is valid this cycle.
- `dest_wb` output 4: register-file write index (registered).
- `Result_WB` output DATA_W: register-file write data (registered).
- `writeBackEn` output 1: register-file write enable; one-cycle pulse per write (registered).
- `mem_stall` output 1: combinational; MEM stage must hold all `mem_*` inputs stable.
- `wb_fwd_valid` output 1: equals `writeBackEn`; for the forwarding unit.
- `wb_fwd_dest` output 4: equals `dest_wb`.
- `retire_cnt` output 32: count of writes performed.
- `drop_r15` output 1: sticky flag; set when a write to index 15 was suppressed.

## Operation
- FSM states: `IDLE`, `LOAD_WAIT`.
- **Accept condition:** `mem_valid & ~freeze & ~mem_stall_internal`.
- **IDLE, accept, `mem_r_en=0`:**
  - Capture `Result_WB<=mem_alu_res` and `dest_wb<=mem_dest`.
  - Set `writeBackEn<=mem_wb_en & (mem_dest!=15)`.
- **IDLE, accept, `mem_r_en=1`, `sram_ready=1`:**
  - Capture `Result_WB<=sram_rdata`, with `dest_wb` and `writeBackEn` set as above.
  - State stays `IDLE`.
- **IDLE, `mem_valid & ~freeze & mem_r_en & ~sram_ready`:**
  - Go to `LOAD_WAIT`.
  - Latch `mem_dest` and `mem_wb_en` into internal registers.
  - `writeBackEn<=0`.
- **LOAD_WAIT, `sram_ready=1`:**
  - Capture `Result_WB<=sram_rdata`, `dest_wb<=` latched dest, `writeBackEn<=` latched wb_en & (dest!=15).
  - Return to `IDLE`.
- **LOAD_WAIT, `sram_ready=0`:** stay in `LOAD_WAIT`; `writeBackEn<=0`.
- **`mem_stall`** = `(state==LOAD_WAIT & ~sram_ready) | (state==IDLE & mem_valid & mem_r_en & ~sram_ready)`.
- **Freeze:**
  - `freeze` does not affect `LOAD_WAIT`; the SRAM completion is still taken.
  - In `IDLE`, freeze blocks acceptance: `writeBackEn<=0`, `dest_wb` and `Result_WB` hold.
- **No accept:** `writeBackEn<=0`; `dest_wb` and `Result_WB` hold their last values.
- **Index 15:** a write with dest 15 and wb_en=1 produces `writeBackEn=0` and sets `drop_r15<=1`. The flag stays set until reset.
- **`retire_cnt`:** increments by 1 on each cycle in which `writeBackEn` is registered as 1; wraps from `0xFFFFFFFF` to 0.

## Timing
- **Reset values:** state `IDLE`; `dest_wb=0`, `Result_WB=0`, `writeBackEn=0`, `retire_cnt=0`, `drop_r15=0`; internal latches 0.
- **Reset during `LOAD_WAIT`:** the pending load is discarded and no write is issued.
- **Latency:**
  - ALU op or ready load accepted at rising edge k: `writeBackEn` is high from edge k to edge k+1, so the register file writes on the falling edge in between.
  - Load stalled for N cycles: the write pulse occurs in the cycle after the edge where `sram_ready` is sampled high.
- **Throughput:** one write per cycle; back-to-back accepts give back-to-back pulses with no bubble.
- **Pulse width:** `writeBackEn` is never high for two cycles from a single instruction.
- **Hold requirement:** `mem_stall` is high in the same cycle as the condition that causes it; upstream holds its inputs until `mem_stall` falls.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> all outputs are 0 immediately; `retire_cnt=0`.
- **ALU stream:** `mem_dest`=3,4,5 with `mem_alu_res`=0x11,0x22,0x33 on consecutive cycles -> three consecutive one-cycle `writeBackEn` pulses with matching `dest_wb` and `Result_WB`; `retire_cnt=3`.
- **Slow load:** load to r7 with `sram_ready` low for 4 cycles, then `sram_rdata=0xDEADBEEF` with ready high ->
  - `mem_stall` high for exactly 4 cycles;
  - a single pulse `dest_wb=7`, `Result_WB=0xDEADBEEF`.
- **Freeze:** `freeze=1` with a valid ALU op for 3 cycles -> no pulses and outputs hold; after release, the write appears 1 cycle later.
- **Index 15:** write with dest 15 and wb_en=1 -> `writeBackEn` stays 0, `drop_r15=1`, `retire_cnt` is unchanged.
- **Reset during load:** reset while in `LOAD_WAIT`, then `sram_ready` pulses -> no write occurs and state is `IDLE`.
